// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared constants and types for the instruction stream driver.
//   CPU_XLEN  : default instruction/result width
//   MAX_XLEN  : widest XLEN the compare pipeline can carry
//   NOP_INSTR : word presented to the CPU whenever nothing is issued
//   stage_t   : one compare-pipeline stage {valid, check, exp}
package cpu_pkg;

  localparam int CPU_XLEN = 32;

  // The stage struct has to be a fixed-width package type, so the expected
  // value is held zero-extended to MAX_XLEN. Any XLEN up to 64 fits.
  localparam int MAX_XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                valid;
    logic                check;
    logic [MAX_XLEN-1:0] exp;
  } stage_t;

endpackage

// File: rtl/instr_stream_driver_if.sv
// instr_stream_driver_if -- producer push channel and CPU-facing signals.
//   push_valid/push_ready/push_instr/push_expect/push_check : queue push
//   run     : enables issue from the queue
//   Instr   : registered instruction to the CPU
//   Result  : CPU result, compared LAT cycles after issue
//   issued  : Instr in this cycle came from the queue
//
// Handshake: push_valid/push_ready is strict valid/ready. A push transfers
// on a rising edge where both are high. push_ready depends only on queue
// occupancy, never on push_valid, so the producer may wait for ready.
interface instr_stream_driver_if
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
);
  logic            push_valid;
  logic            push_ready;
  logic [XLEN-1:0] push_instr;
  logic [XLEN-1:0] push_expect;
  logic            push_check;
  logic            run;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] Result;
  logic            issued;

  // master: producer plus CPU model side
  modport master (
    output push_valid, push_instr, push_expect, push_check, run, Result,
    input  push_ready, Instr, issued
  );

  // slave: the driver itself
  modport slave (
    input  push_valid, push_instr, push_expect, push_check, run, Result,
    output push_ready, Instr, issued
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock queue with registered pointers.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : write request (ignored while full)
//   wr_data  : entry to write
//   rd_en    : read request (ignored while empty)
//   rd_data  : head entry, valid whenever level > 0
//   level    : occupancy, 0..DEPTH
// A full queue refuses a write even when a read happens on the same edge.
// There is no bypass: a written entry is readable from the next cycle on.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_fire = wr_en && (level < FULL_LVL);
  assign rd_fire = rd_en && (level != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/instr_stream_driver.sv
// instr_stream_driver -- feeds queued instructions to a CPU and checks the
// CPU results against expected values LAT cycles later.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : push channel, run, Instr/Result/issued (slave modport)
//   mismatch   : one-cycle pulse after a checked result differed
//   pass_count : checked results that matched (saturating)
//   err_count  : checked results that differed (saturating)
//   level      : queue occupancy
//   done       : queue empty and no comparison in flight
module instr_stream_driver
  import cpu_pkg::*;
#(
  parameter int XLEN  = CPU_XLEN,
  parameter int DEPTH = 16,
  parameter int LAT   = 1,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_stream_driver_if.slave   bus,
  output logic                   mismatch,
  output logic [CNTW-1:0]        pass_count,
  output logic [CNTW-1:0]        err_count,
  output logic [$clog2(DEPTH):0] level,
  output logic                   done
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [LW-1:0]   fifo_level;
  logic [EW-1:0]   head;
  logic            head_check;
  logic [XLEN-1:0] head_exp;
  logic [XLEN-1:0] head_instr;
  logic            push_fire;
  logic            pop;

  stage_t pipe [LAT];
  stage_t stage_in;
  stage_t tail;
  logic   cmp_en;
  logic   cmp_eq;
  logic   any_valid;

  assign bus.push_ready = (fifo_level < FULL_LVL);
  assign push_fire      = bus.push_valid && bus.push_ready;
  assign pop            = bus.run && (fifo_level != '0);
  assign {head_check, head_exp, head_instr} = head;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_fire),
    .wr_data ({bus.push_check, bus.push_expect, bus.push_instr}),
    .rd_en   (pop),
    .rd_data (head),
    .level   (fifo_level)
  );

  // Issue register: the head word on a pop edge, NOP on every other edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Instr  <= XLEN'(NOP_INSTR);
      bus.issued <= 1'b0;
    end else if (pop) begin
      bus.Instr  <= head_instr;
      bus.issued <= 1'b1;
    end else begin
      bus.Instr  <= XLEN'(NOP_INSTR);
      bus.issued <= 1'b0;
    end
  end

  // Stage 1 takes the popped entry or a bubble.
  always_comb begin
    stage_in = '0;
    if (pop) begin
      stage_in.valid = 1'b1;
      stage_in.check = head_check;
      stage_in.exp   = MAX_XLEN'(head_exp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The last stage lines up with the Result of the instruction it tracks.
  assign tail   = pipe[LAT-1];
  assign cmp_en = tail.valid && tail.check;
  assign cmp_eq = (tail.exp == MAX_XLEN'(bus.Result));

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch   <= 1'b0;
      pass_count <= '0;
      err_count  <= '0;
    end else begin
      mismatch <= cmp_en && !cmp_eq;
      if (cmp_en && cmp_eq && (pass_count != '1)) pass_count <= pass_count + 1'b1;
      if (cmp_en && !cmp_eq && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) any_valid = any_valid | pipe[i].valid;
  end

  assign level = fifo_level;
  assign done  = (fifo_level == '0) && !any_valid;
endmodule

// File: tb/tb_instr_stream_driver.sv
module tb_instr_stream_driver;
  import cpu_pkg::*;

  localparam int DEP = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  // dut_a: LAT=1, wide counters.  dut_b: LAT=3, 2-bit counters.
  instr_stream_driver_if #(.XLEN(32)) bus_a ();
  instr_stream_driver_if #(.XLEN(32)) bus_b ();

  logic        mm_a, mm_b, done_a, done_b;
  logic [15:0] pass_a, err_a;
  logic [1:0]  pass_b, err_b;
  logic [2:0]  lvl_a_o, lvl_b_o;

  instr_stream_driver #(.XLEN(32), .DEPTH(DEP), .LAT(1), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .mismatch(mm_a),
    .pass_count(pass_a), .err_count(err_a), .level(lvl_a_o), .done(done_a)
  );

  instr_stream_driver #(.XLEN(32), .DEPTH(DEP), .LAT(3), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .mismatch(mm_b),
    .pass_count(pass_b), .err_count(err_b), .level(lvl_b_o), .done(done_b)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int lvl_a = 0, lvl_b = 0;
  int pass_ma = 0, err_ma = 0, pass_mb = 0, err_mb = 0;
  logic [31:0] exp_qa[$];
  logic [31:0] res_qa[$];
  logic [31:0] exp_qb[$];
  logic [31:0] res_qb[$];
  logic [31:0] d0 = '0, d1 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // ---------------- CPU models / output monitors ----------------
  // LAT=1: the result is needed in the same cycle the instruction appears.
  always @(negedge clk) begin
    bus_a.Result = $urandom;
    if (bus_a.issued === 1'b1) begin
      check("a_issue_expected", 64'(exp_qa.size() != 0), 64'd1);
      if (exp_qa.size() != 0) begin
        check("a_instr_order", 64'(bus_a.Instr), 64'(exp_qa.pop_front()));
        bus_a.Result = res_qa.pop_front();
      end
    end
  end

  // LAT=3: the result is needed two cycles after the instruction appears.
  always @(negedge clk) begin
    bus_b.Result = d1;
    d1 = d0;
    d0 = $urandom;
    if (bus_b.issued === 1'b1) begin
      check("b_issue_expected", 64'(exp_qb.size() != 0), 64'd1);
      if (exp_qb.size() != 0) begin
        check("b_instr_order", 64'(bus_b.Instr), 64'(exp_qb.pop_front()));
        d0 = res_qb.pop_front();
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int sat3(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  task automatic idle_all();
    bus_a.push_valid = 1'b0; bus_a.push_instr = '0; bus_a.push_expect = '0;
    bus_a.push_check = 1'b0; bus_a.run = 1'b0;
    bus_b.push_valid = 1'b0; bus_b.push_instr = '0; bus_b.push_expect = '0;
    bus_b.push_check = 1'b0; bus_b.run = 1'b0;
  endtask

  // One cycle on dut_a; rs is the result the CPU model will return.
  task automatic tick_a(input logic pv, input logic [31:0] ins, input logic [31:0] ex,
                        input logic [31:0] rs, input logic ck, input logic r);
    int pushed, popped;
    bus_a.push_valid = pv; bus_a.push_instr = ins; bus_a.push_expect = ex;
    bus_a.push_check = ck; bus_a.run = r;
    pushed = (pv && lvl_a < DEP) ? 1 : 0;
    popped = (r && lvl_a > 0) ? 1 : 0;
    if (pushed == 1) begin
      exp_qa.push_back(ins);
      res_qa.push_back(rs);
      if (ck) begin
        if (rs == ex) pass_ma++;
        else err_ma++;
      end
    end
    lvl_a = lvl_a + pushed - popped;
    @(negedge clk);
  endtask

  task automatic tick_b(input logic pv, input logic [31:0] ins, input logic [31:0] ex,
                        input logic [31:0] rs, input logic ck, input logic r);
    int pushed, popped;
    bus_b.push_valid = pv; bus_b.push_instr = ins; bus_b.push_expect = ex;
    bus_b.push_check = ck; bus_b.run = r;
    pushed = (pv && lvl_b < DEP) ? 1 : 0;
    popped = (r && lvl_b > 0) ? 1 : 0;
    if (pushed == 1) begin
      exp_qb.push_back(ins);
      res_qb.push_back(rs);
      if (ck) begin
        if (rs == ex) pass_mb = sat3(pass_mb);
        else err_mb = sat3(err_mb);
      end
    end
    lvl_b = lvl_b + pushed - popped;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] e;
    idle_all();
    bus_a.Result = '0;
    bus_b.Result = '0;
    rst = 1'b1;
    // Reset must win over push_valid and run.
    bus_a.push_valid = 1'b1; bus_a.run = 1'b1;
    bus_b.push_valid = 1'b1; bus_b.run = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_level", 64'(lvl_a_o), 64'd0);
    check("rst_a_ready", 64'(bus_a.push_ready), 64'd1);
    check("rst_a_done", 64'(done_a), 64'd1);
    check("rst_a_instr", 64'(bus_a.Instr), 64'(NOP_INSTR));
    check("rst_a_issued", 64'(bus_a.issued), 64'd0);
    check("rst_a_mismatch", 64'(mm_a), 64'd0);
    check("rst_a_pass", 64'(pass_a), 64'd0);
    check("rst_a_err", 64'(err_a), 64'd0);
    check("rst_b_level", 64'(lvl_b_o), 64'd0);
    check("rst_b_done", 64'(done_b), 64'd1);
    check("rst_b_instr", 64'(bus_b.Instr), 64'(NOP_INSTR));
    check("rst_b_counts", 64'({pass_b, err_b}), 64'd0);
    rst = 1'b0;
    idle_all();

    // Single checked entry, LAT=1.
    tick_a(1'b1, 32'h0050_0093, 32'd5, 32'd5, 1'b1, 1'b0);
    check("one_not_issued_yet", 64'(bus_a.issued), 64'd0);
    tick_a(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("one_issued", 64'(bus_a.issued), 64'd1);
    check("one_instr", 64'(bus_a.Instr), 64'h0050_0093);
    tick_a(1'b0, '0, '0, '0, 1'b0, 1'b0);
    check("one_issue_ends", 64'(bus_a.issued), 64'd0);
    check("one_nop_after", 64'(bus_a.Instr), 64'(NOP_INSTR));
    check("one_pass", 64'(pass_a), 64'd1);
    check("one_no_mismatch", 64'(mm_a), 64'd0);
    check("one_done", 64'(done_a), 64'd1);

    // Fill to DEPTH with run low, then offer a 5th.
    for (int i = 0; i < DEP; i++) begin
      e = 32'h1000_0000 + 32'(i);
      tick_a(1'b1, e, ~e, ~e, 1'b1, 1'b0);
    end
    check("full_level", 64'(lvl_a_o), 64'(lvl_a));
    check("full_not_ready", 64'(bus_a.push_ready), 64'd0);
    check("full_instr_nop", 64'(bus_a.Instr), 64'(NOP_INSTR));
    tick_a(1'b1, 32'hDEAD_0005, '0, '0, 1'b1, 1'b0);
    check("fifth_refused_level", 64'(lvl_a_o), 64'd4);
    check("fifth_instr_nop", 64'(bus_a.Instr), 64'(NOP_INSTR));
    // Full queue with push and pop on the same edge: push is still refused.
    tick_a(1'b1, 32'hDEAD_0006, '0, '0, 1'b1, 1'b1);
    check("full_pushpop_level", 64'(lvl_a_o), 64'(DEP - 1));
    check("full_pushpop_ready", 64'(bus_a.push_ready), 64'd1);

    // Stream 2*DEPTH entries across pointer wrap; one unchecked with a bad result.
    for (int i = 0; i < 2 * DEP; i++) begin
      e = $urandom;
      tick_a(1'b1, 32'h2000_0000 + 32'(i), e, (i == 3) ? (e ^ 32'h1) : e, (i != 3), 1'b1);
    end
    repeat (8) tick_a(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("stream_drained", 64'(exp_qa.size()), 64'd0);
    check("stream_level", 64'(lvl_a_o), 64'd0);
    check("stream_done", 64'(done_a), 64'd1);
    check("stream_pass", 64'(pass_a), 64'(pass_ma));
    check("stream_err", 64'(err_a), 64'(err_ma));
    bus_a.run = 1'b0;

    // LAT=3: three checked entries, the second one returns a wrong result.
    tick_b(1'b1, 32'h3000_0000, 32'h11, 32'h11, 1'b1, 1'b0);
    tick_b(1'b1, 32'h3000_0001, 32'h22, 32'h99, 1'b1, 1'b0);
    tick_b(1'b1, 32'h3000_0002, 32'h33, 32'h33, 1'b1, 1'b0);
    // Cycle c follows issue edge k0+c; the 2nd entry issues at k0+1.
    for (int c = 0; c < 8; c++) begin
      tick_b(1'b0, '0, '0, '0, 1'b0, 1'b1);
      check("lat3_mismatch_pulse", 64'(mm_b), 64'(c == 4));
    end
    check("lat3_err", 64'(err_b), 64'd1);
    check("lat3_pass", 64'(pass_b), 64'd2);
    check("lat3_done", 64'(done_b), 64'd1);

    // Saturation of a 2-bit err_count.
    for (int i = 0; i < 5; i++)
      tick_b(1'b1, 32'h4000_0000 + 32'(i), 32'(i), 32'(i) ^ 32'hFF, 1'b1, 1'b1);
    repeat (8) tick_b(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("sat_err", 64'(err_b), 64'(err_mb));
    check("sat_err_is_max", 64'(err_b), 64'd3);
    check("sat_pass", 64'(pass_b), 64'(pass_mb));
    tick_b(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("sat_err_holds", 64'(err_b), 64'd3);

    // Mid-stream reset: 4 queued, then 2 popped into the pipeline.
    for (int i = 0; i < DEP; i++)
      tick_b(1'b1, 32'h5000_0000 + 32'(i), 32'h55 + 32'(i), 32'h55 + 32'(i), 1'b1, 1'b0);
    tick_b(1'b0, '0, '0, '0, 1'b0, 1'b1);
    tick_b(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("pre_rst_level", 64'(lvl_b_o), 64'd2);
    rst = 1'b1;
    bus_b.push_valid = 1'b1; bus_b.push_instr = 32'hBAD0_0000; bus_b.run = 1'b1;
    @(negedge clk);
    check("mid_rst_level", 64'(lvl_b_o), 64'd0);
    check("mid_rst_counts", 64'({pass_b, err_b}), 64'd0);
    check("mid_rst_instr", 64'(bus_b.Instr), 64'(NOP_INSTR));
    check("mid_rst_issued", 64'(bus_b.issued), 64'd0);
    check("mid_rst_done", 64'(done_b), 64'd1);
    check("mid_rst_ready", 64'(bus_b.push_ready), 64'd1);
    rst = 1'b0;
    idle_all();
    exp_qb.delete();
    res_qb.delete();
    lvl_b = 0;
    // The CPU model keeps returning the stale (matching) results.
    repeat (6) tick_b(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("stale_pass", 64'(pass_b), 64'd0);
    check("stale_err", 64'(err_b), 64'd0);
    check("stale_mismatch", 64'(mm_b), 64'd0);
    check("stale_done", 64'(done_b), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
